// File: rtl/logic_op_sequencer_pkg.sv
// Shared types, sizes and bit-search helpers for the logic-op sequencer.
package logic_op_sequencer_pkg;

  localparam int NUM_OPS = 8;
  localparam int SEL_W   = 3;
  localparam int HOLD_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Lowest set bit of mask. The MSB of the result is the "found" flag and the
  // low SEL_W bits are the index. Scanning from the top down means the last
  // match written is the lowest one.
  function automatic logic [SEL_W:0] first_set_bit(input logic [NUM_OPS-1:0] mask);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction

  // Lowest set bit strictly above idx. This is a plain priority search, so
  // unselected codes cost no cycles. The result uses the same found/index
  // packing as first_set_bit.
  function automatic logic [SEL_W:0] next_set_bit(input logic [NUM_OPS-1:0] mask,
                                                  input logic [SEL_W-1:0]   idx);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/configurable_logic.sv
// Single-bit configurable logic unit: SEL picks one of eight two-input functions.
//   0 AND   1 OR   2 XOR   3 NAND   4 NOR   5 XNOR   6 NOT A   7 NOT B
module configurable_logic
  import logic_op_sequencer_pkg::*;
(
  input  logic             i_a,
  input  logic             i_b,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_y
);

  logic [NUM_OPS-1:0] w_ops;

  assign w_ops[0] = i_a & i_b;
  assign w_ops[1] = i_a | i_b;
  assign w_ops[2] = i_a ^ i_b;
  assign w_ops[3] = ~(i_a & i_b);
  assign w_ops[4] = ~(i_a | i_b);
  assign w_ops[5] = ~(i_a ^ i_b);
  assign w_ops[6] = ~i_a;
  assign w_ops[7] = ~i_b;

  // Output mux driven by the code currently applied
  always_comb begin
    o_y = w_ops[i_sel];
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Sweeps the SEL codes chosen by a mask through configurable_logic. Each code is
// held for HOLD_CYCLES cycles, and Y is collected into one result bit per code.
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               a_in,
  input  logic               b_in,
  input  logic [NUM_OPS-1:0] op_mask,
  output logic               busy,
  output logic [SEL_W-1:0]   sel_o,
  output logic [NUM_OPS-1:0] result,
  output logic [3:0]         op_count,
  output logic               result_valid,
  input  logic               result_ack
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t             r_state;
  logic               r_a;
  logic               r_b;
  logic [NUM_OPS-1:0] r_mask;
  logic [SEL_W-1:0]   r_sel;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [NUM_OPS-1:0] r_result;
  logic [3:0]         r_op_count;
  logic               r_valid;
  logic               r_busy;

  logic               w_y;
  logic [SEL_W:0]     w_first;
  logic [SEL_W:0]     w_next;

  // sel_o doubles as the sweep index. It is forced to 0 outside APPLY, so the
  // unit always sees the same code the debug port shows.
  configurable_logic u_logic (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_sel (r_sel),
    .o_y   (w_y)
  );

  // First code for a new sweep, and the code that follows the current one
  always_comb begin
    w_first = first_set_bit(op_mask);
    w_next  = next_set_bit(r_mask, r_sel);
  end

  // Sweep FSM; every output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_mask     <= '0;
      r_sel      <= '0;
      r_hold_cnt <= '0;
      r_result   <= '0;
      r_op_count <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_mask     <= op_mask;
            r_result   <= '0;
            r_op_count <= '0;
            r_hold_cnt <= '0;
            if (w_first[SEL_W]) begin
              r_state <= ST_APPLY;
              r_sel   <= w_first[SEL_W-1:0];
              r_busy  <= 1'b1;
            end else begin
              // Empty mask: there is nothing to apply, so report at once
              r_state <= ST_DONE;
              r_valid <= 1'b1;
            end
          end
        end

        ST_APPLY: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_result[r_sel] <= w_y;
            r_op_count      <= r_op_count + 4'd1;
            r_hold_cnt      <= '0;
            if (w_next[SEL_W]) begin
              r_sel <= w_next[SEL_W-1:0];
            end else begin
              r_state <= ST_DONE;
              r_sel   <= '0;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // start is deliberately ignored here, even on the ack edge
          if (result_ack) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_sel   <= '0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign sel_o        = r_sel;
  assign result       = r_result;
  assign op_count     = r_op_count;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer. It uses one instance with HOLD_CYCLES=1
// and one with HOLD_CYCLES=3.
module tb_logic_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in, b_in;
  logic [7:0] op_mask;

  logic       start1, ack1, busy1, valid1;
  logic [2:0] sel1;
  logic [7:0] result1;
  logic [3:0] cnt1;

  logic       start3, ack3, busy3, valid3;
  logic [2:0] sel3;
  logic [7:0] result3;
  logic [3:0] cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_op_sequencer #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in),
    .op_mask(op_mask), .busy(busy1), .sel_o(sel1), .result(result1),
    .op_count(cnt1), .result_valid(valid1), .result_ack(ack1)
  );

  logic_op_sequencer #(.HOLD_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a_in), .b_in(b_in),
    .op_mask(op_mask), .busy(busy3), .sel_o(sel3), .result(result3),
    .op_count(cnt3), .result_valid(valid3), .result_ack(ack3)
  );

  // Standalone golden logic unit
  function automatic logic gold_op(input logic a, input logic b, input int sel);
    case (sel)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return ~a;
      default: return ~b;
    endcase
  endfunction

  function automatic logic [7:0] gold_result(input logic a, input logic b, input logic [7:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = m[i] & gold_op(a, b, i);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on dut1, then scramble the inputs to prove capture. The
  // latency returned is the number of edges after the start edge until valid.
  task automatic sweep1(input logic a, input logic b, input logic [7:0] m, output int lat);
    a_in = a; b_in = b; op_mask = m; start1 = 1'b1;
    tick();
    start1 = 1'b0; a_in = ~a; b_in = ~b; op_mask = ~m;
    lat = 0;
    while (!valid1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack_dut1();
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("ack_clears_valid", 32'(valid1), 32'd0);
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] mask;
    logic [7:0] exp_res;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [7:0] held;
    int exp_sel3[9];

    // A/B truth tables: 10 -> 8E, 00 -> F8, 11 -> 23, 01 -> 4E
    vecs[0] = '{1'b1, 1'b0, 8'hFF, 8'h8E, 8};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 0};
    vecs[2] = '{1'b1, 1'b1, 8'hA5, 8'h21, 4};
    vecs[3] = '{1'b0, 1'b1, 8'h3C, 8'h0C, 4};
    vecs[4] = '{1'b0, 1'b0, 8'h80, 8'h80, 1};
    vecs[5] = '{1'b1, 1'b0, 8'h01, 8'h00, 1};
    vecs[6] = '{1'b0, 1'b1, 8'h0F, 8'h0E, 4};
    exp_sel3 = '{0, 0, 0, 5, 5, 5, 7, 7, 7};

    rst = 1'b1; start1 = 0; ack1 = 0; start3 = 0; ack3 = 0;
    a_in = 0; b_in = 0; op_mask = 0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_sel", 32'(sel1), 32'd0);
    check("reset_result", 32'(result1), 32'd0);
    check("reset_count", 32'(cnt1), 32'd0);
    check("reset_valid", 32'(valid1), 32'd0);

    // Full sweep on HOLD=1: sel_o steps 0..7, one code per cycle
    a_in = 1; b_in = 0; op_mask = 8'hFF; start1 = 1;
    tick();
    start1 = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ff_sel_%0d", k), 32'(sel1), 32'(k));
      check($sformatf("ff_busy_%0d", k), 32'(busy1), 32'd1);
      check($sformatf("ff_novalid_%0d", k), 32'(valid1), 32'd0);
      tick();
    end
    check("ff_valid_at_e8", 32'(valid1), 32'd1);
    check("ff_result", 32'(result1), 32'(gold_result(1, 0, 8'hFF)));
    check("ff_count", 32'(cnt1), 32'd8);
    check("ff_sel_done", 32'(sel1), 32'd0);
    ack_dut1();

    // Table-driven vectors on HOLD=1
    for (int v = 0; v < 7; v++) begin
      sweep1(vecs[v].a, vecs[v].b, vecs[v].mask, lat);
      $display("vec %0d a=%0b b=%0b mask=%02h lat=%0d result=%02h count=%0d",
               v, vecs[v].a, vecs[v].b, vecs[v].mask, lat, result1, cnt1);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_result", v), 32'(result1), 32'(vecs[v].exp_res));
      check($sformatf("vec%0d_gold", v), 32'(result1),
            32'(gold_result(vecs[v].a, vecs[v].b, vecs[v].mask)));
      check($sformatf("vec%0d_count", v), 32'(cnt1), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_busy", v), 32'(busy1), 32'd0);
      ack_dut1();
    end

    // HOLD=3 with a sparse mask: each selected code is held for 3 cycles
    a_in = 1; b_in = 0; op_mask = 8'b1010_0001; start3 = 1;
    tick();
    start3 = 0; a_in = 0; b_in = 1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("h3_sel_%0d", k), 32'(sel3), 32'(exp_sel3[k]));
      check($sformatf("h3_novalid_%0d", k), 32'(valid3), 32'd0);
      tick();
    end
    $display("hold3 sweep result=%02h count=%0d valid=%0b", result3, cnt3, valid3);
    check("h3_valid_at_e9", 32'(valid3), 32'd1);
    check("h3_result", 32'(result3), 32'h80);
    check("h3_gold", 32'(result3), 32'(gold_result(1, 0, 8'b1010_0001)));
    check("h3_count", 32'(cnt3), 32'd3);
    ack3 = 1; tick(); ack3 = 0;
    check("h3_ack", 32'(valid3), 32'd0);

    // Hold DONE for 10 cycles with a start pulse in the middle
    sweep1(0, 1, 8'h3C, lat);
    held = result1;
    check("hold_result", 32'(held), 32'h0C);
    for (int k = 0; k < 10; k++) begin
      start1 = (k == 4);
      tick();
      check($sformatf("hold_valid_%0d", k), 32'(valid1), 32'd1);
      check($sformatf("hold_stable_%0d", k), 32'(result1), 32'(held));
      check($sformatf("hold_busy_%0d", k), 32'(busy1), 32'd0);
    end
    start1 = 0;
    ack_dut1();
    sweep1(1, 1, 8'h02, lat);
    $display("restart after ack lat=%0d result=%02h", lat, result1);
    check("restart_latency", 32'(lat), 32'd1);
    check("restart_result", 32'(result1), 32'h02);
    ack_dut1();

    // Reset in the middle of APPLY, after two ops
    a_in = 1; b_in = 0; op_mask = 8'hFF; start1 = 1;
    tick();
    start1 = 0;
    tick(); tick();
    check("midrst_two_ops", 32'(cnt1), 32'd2);
    rst = 1; ack1 = 1; start1 = 1;
    tick();
    rst = 0; ack1 = 0; start1 = 0;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_sel", 32'(sel1), 32'd0);
    check("midrst_result", 32'(result1), 32'd0);
    check("midrst_count", 32'(cnt1), 32'd0);
    check("midrst_valid", 32'(valid1), 32'd0);
    tick();
    check("midrst_idle", 32'(busy1), 32'd0);
    sweep1(0, 0, 8'hFF, lat);
    $display("post-reset sweep lat=%0d result=%02h count=%0d", lat, result1, cnt1);
    check("postrst_latency", 32'(lat), 32'd8);
    check("postrst_result", 32'(result1), 32'hF8);
    check("postrst_count", 32'(cnt1), 32'd8);
    ack_dut1();

    // ack and start on the same DONE edge: return to IDLE without starting
    sweep1(1, 0, 8'h81, lat);
    check("same_edge_result", 32'(result1), 32'h80);
    a_in = 1; b_in = 0; op_mask = 8'hFF;
    ack1 = 1; start1 = 1;
    tick();
    ack1 = 0; start1 = 0;
    check("same_edge_valid", 32'(valid1), 32'd0);
    check("same_edge_busy", 32'(busy1), 32'd0);
    tick();
    check("same_edge_busy_next", 32'(busy1), 32'd0);
    check("same_edge_valid_next", 32'(valid1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
